// File: rtl/button_debouncer.sv
// button_debouncer
//   Per-button input conditioner for the stopwatch push-buttons. Each channel
//   has a 2-flop synchroniser, a stable-level debounce FSM and a counter. The
//   block produces a clean debounced level and a one-cycle pulse for each
//   qualified press.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   buttons_in     raw button levels (async to clk), 1 = pressed
//                  bit order: one=0, ten=1, pause=2, clear=3
//   buttons_level  debounced level per channel (registered)
//   buttons_pulse  one-cycle pulse per qualified press (registered)
//   any_pulse      OR of buttons_pulse, registered alongside it
module button_debouncer #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    output logic [NUM_BUTTONS-1:0] buttons_level,
    output logic [NUM_BUTTONS-1:0] buttons_pulse,
    output logic                   any_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [NUM_BUTTONS-1:0] sync1_q;
    logic [NUM_BUTTONS-1:0] sync2_q;

    state_t                 state_q [NUM_BUTTONS];
    state_t                 state_d [NUM_BUTTONS];
    logic [CW-1:0]          cnt_q   [NUM_BUTTONS];
    logic [CW-1:0]          cnt_d   [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] level_q;
    logic [NUM_BUTTONS-1:0] level_d;
    logic [NUM_BUTTONS-1:0] pulse_q;
    logic [NUM_BUTTONS-1:0] pulse_d;
    logic                   any_q;

    always_comb begin
        level_d = '0;
        pulse_d = '0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            // Level is a registered copy of "next state is a pressed state",
            // so it changes on the same edge as the state register.
            level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_WAIT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            level_q <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
        end else begin
            sync1_q <= buttons_in;
            sync2_q <= sync1_q;
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q <= level_d;
            pulse_q <= pulse_d;
            any_q   <= |pulse_d;
        end
    end

    assign buttons_level = level_q;
    assign buttons_pulse = pulse_q;
    assign any_pulse     = any_q;

endmodule
